// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers BCD frames from a scanned 7-segment bus; optional `SEG_RANGE_CHECK_EN rejects non-HH:MM:SS frames
module seg_scan_decoder #(
  parameter int NUM_DIGITS = 6,
  parameter int STABLE_CYC = 16,
  parameter int TIMEOUT_CYC = 2000000,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit DIG_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] seg7,
  input  logic [7:0] number,
  input  logic clr_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0] dp,
  output logic frame_stb,
  output logic frame_valid,
  output logic err,
  output logic stale,
  output logic range_err
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] DIG_OFF = DIG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state, state_nx;
  logic [7:0] seg_q1, seg_q2, num_q1, num_q2, s_seg, s_num, ref_seg;
  logic [NUM_DIGITS-1:0] s_dig, ref_dig, seen, w_dp;
  logic [4*NUM_DIGITS-1:0] w_dig;
  logic [CW-1:0] stab_cnt, cnt_nx;
  logic [TW-1:0] idle_cnt;
  logic [IW-1:0] idx;
  logic [3:0] code;
  logic valid, same, load, cap, publish, timed_out, legal, unused_num;
  function automatic logic [3:0] decode(input logic [6:0] g);
    case (g)
      7'h3F: decode = 4'd0;
      7'h06: decode = 4'd1;
      7'h5B: decode = 4'd2;
      7'h4F: decode = 4'd3;
      7'h66: decode = 4'd4;
      7'h6D: decode = 4'd5;
      7'h7D: decode = 4'd6;
      7'h07: decode = 4'd7;
      7'h7F: decode = 4'd8;
      7'h6F: decode = 4'd9;
      7'h00: decode = 4'hF;
      default: decode = 4'hE;
    endcase
  endfunction
  // XOR with the idle level turns both buses active-high
  assign s_seg = seg_q2 ^ SEG_OFF;
  assign s_num = num_q2 ^ DIG_OFF;
  assign s_dig = s_num[NUM_DIGITS-1:0];
  assign unused_num = ^(s_num >> NUM_DIGITS);
  assign valid = |s_dig && !(|(s_dig & (s_dig - 1'b1)));
  assign same = s_seg == ref_seg && s_dig == ref_dig;
  assign publish = &seen;
  assign timed_out = idle_cnt == T_MAX;
  assign code = decode(ref_seg[6:0]);
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (ref_dig[i]) idx = IW'(i);
  end
  always_comb begin
    state_nx = state;
    cnt_nx = stab_cnt;
    load = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE: if (valid) begin
        state_nx = SETTLE;
        cnt_nx = CW'(1);
        load = 1'b1;
      end
      SETTLE: if (!same) begin
        load = valid;
        cnt_nx = CW'(1);
        state_nx = valid ? SETTLE : IDLE;
      end else begin
        cnt_nx = stab_cnt + 1'b1;
        cap = cnt_nx == CW'(STABLE_CYC);
        state_nx = cap ? HOLD : SETTLE;
      end
      default: state_nx = same ? HOLD : IDLE;
    endcase
  end
`ifdef SEG_RANGE_CHECK_EN
  always_comb begin
    legal = w_dig[7:4] <= 4'd5 && w_dig[15:12] <= 4'd5 &&
            (w_dig[23:20] < 4'd2 || (w_dig[23:20] == 4'd2 && w_dig[19:16] <= 4'd3));
    for (int i = 0; i < NUM_DIGITS; i++) legal = legal && w_dig[4*i +: 4] <= 4'd9;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) range_err <= 1'b0;
    else range_err <= publish && !legal;
`else
  assign legal = 1'b1;
  assign range_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {seg_q1, seg_q2} <= {SEG_OFF, SEG_OFF};
      {num_q1, num_q2} <= {DIG_OFF, DIG_OFF};
      state <= IDLE;
      stab_cnt <= '0;
      ref_seg <= '0;
      ref_dig <= '0;
      w_dig <= '0;
      w_dp <= '0;
      seen <= '0;
      digits <= '0;
      dp <= '0;
      frame_stb <= 1'b0;
      frame_valid <= 1'b0;
      err <= 1'b0;
      stale <= 1'b0;
      idle_cnt <= '0;
    end else begin
      {seg_q2, seg_q1} <= {seg_q1, seg7};
      {num_q2, num_q1} <= {num_q1, number};
      state <= state_nx;
      stab_cnt <= cnt_nx;
      if (load) {ref_seg, ref_dig} <= {s_seg, s_dig};
      if (cap) begin
        w_dig[4*idx +: 4] <= code;
        w_dp[idx] <= ref_seg[7];
      end
      seen <= cap ? seen | ref_dig : (publish || timed_out) ? '0 : seen;
      frame_stb <= publish;
      if (publish) frame_valid <= 1'b1;
      if (publish && legal) {digits, dp} <= {w_dig, w_dp};
      err <= (cap && code == 4'hE) || (err && !clr_err);
      idle_cnt <= cap ? '0 : timed_out ? idle_cnt : idle_cnt + 1'b1;
      stale <= cap ? 1'b0 : timed_out ? 1'b1 : stale;
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans checked against a frame-level model of the display receiver
module tb_seg_scan_decoder;
  localparam int STAB = 16;
  localparam int TMO = 500;
  typedef struct packed {logic [23:0] d; logic [5:0] p; logic re;} frame_t;
  logic clk = 0, rst = 1, clr_err = 0;
  logic [7:0] seg7 = 8'hFF, number = 8'hFF;
  logic [23:0] digits;
  logic [5:0] dp;
  logic frame_stb, frame_valid, err, stale, range_err;
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  frame_t exp_q[$];
  logic [23:0] m_slot = 0, m_pub = 0, last_d = 0;
  logic [5:0] m_dp = 0, m_pubdp = 0, m_seen = 0, last_p = 0;
  logic m_err = 0, exp_fv = 0;
  int total = 0, bad = 0, nstb = 0;
  seg_scan_decoder #(.NUM_DIGITS(6), .STABLE_CYC(STAB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .seg7(seg7), .number(number), .clr_err(clr_err),
    .digits(digits), .dp(dp), .frame_stb(frame_stb), .frame_valid(frame_valid),
    .err(err), .stale(stale), .range_err(range_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic frame_ok(input logic [23:0] v);
    int h;
    h = int'(v[23:20]) * 10 + int'(v[19:16]);
    frame_ok = 1'b1;
`ifdef SEG_RANGE_CHECK_EN
    frame_ok = h <= 23 && v[15:12] <= 5 && v[7:4] <= 5;
    for (int i = 0; i < 6; i++) if (v[4*i +: 4] > 9) frame_ok = 1'b0;
`endif
  endfunction
  // a glyph held long enough lands in its slot; a full slot set yields one expected frame
  task automatic strobe(input logic [7:0] sel, input logic [6:0] g, input logic dpb, input int n);
    int d;
    logic [3:0] v;
    frame_t f;
    if (n >= STAB + 1 && $onehot(sel[5:0])) begin
      d = 0;
      for (int k = 0; k < 6; k++) if (sel[k]) d = k;
      v = g == 0 ? 4'hF : 4'hE;
      for (int k = 0; k < 10; k++) if (pat[k] == g) v = 4'(k);
      if (v == 4'hE) m_err = 1;
      m_slot[4*d +: 4] = v;
      m_dp[d] = dpb;
      m_seen[d] = 1;
      if (&m_seen) begin
        m_seen = 0;
        f.re = !frame_ok(m_slot);
        if (!f.re) begin
          m_pub = m_slot;
          m_pubdp = m_dp;
        end
        f.d = m_pub;
        f.p = m_pubdp;
        exp_q.push_back(f);
      end
    end
    seg7 = ~{dpb, g};
    number = ~sel;
    repeat (n) @(negedge clk);
  endtask
  task automatic scan(input logic [23:0] v, input logic [5:0] dpm, input int bad_d, input int n);
    for (int d = 0; d < 6; d++)
      strobe(8'(1 << d), d == bad_d ? 7'h49 : pat[v[4*d +: 4]], dpm[d], n);
  endtask
  task automatic blank(input int n);
    seg7 = 8'hFF;
    number = 8'hFF;
    repeat (n) @(negedge clk);
  endtask
  initial forever begin
    frame_t f;
    @(negedge clk);
    if (!rst) begin
      chk("rst_digits", digits, 0);
      chk("rst_dp", dp, 0);
      chk("rst_stb", frame_stb, 0);
      chk("rst_fv", frame_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_stale", stale, 0);
      chk("rst_range", range_err, 0);
      last_d = 0;
      last_p = 0;
      exp_fv = 0;
    end else begin
      if (frame_stb) begin
        nstb++;
        chk("stb_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          chk("frame_digits", digits, f.d);
          chk("frame_dp", dp, f.p);
          chk("frame_range", range_err, f.re);
          last_d = f.d;
          last_p = f.p;
          exp_fv = 1;
        end
      end else begin
        chk("hold_digits", digits, last_d);
        chk("hold_dp", dp, last_p);
        chk("range_idle", range_err, 0);
      end
      chk("frame_valid", frame_valid, exp_fv);
    end
  end
  initial begin
    #1 rst = 0;
    repeat (4) @(negedge clk);
    #1 rst = 1;
    scan(24'h123456, 6'b010100, 7, 64);
    chk("scan1_digits", digits, 24'h123456);
    chk("scan1_dp", dp, 6'b010100);
    chk("scan1_fv", frame_valid, 1);
    chk("scan1_err", err, 0);
    chk("scan1_nstb", nstb, 1);
    scan(24'h123456, 6'b010100, 7, 64);
    chk("scan2_nstb", nstb, 2);
    strobe(8'b0000_0011, 7'h3F, 0, 40);
    scan(24'h203145, 0, 7, 64);
    chk("multihot_digits", digits, 24'h203145);
    chk("multihot_nstb", nstb, 3);
    scan(24'h123456, 0, 2, 64);
    chk("bad_err", err, m_err);
    chk("bad_err_lit", err, 1);
`ifdef SEG_RANGE_CHECK_EN
    chk("bad_digits", digits, 24'h203145);
`else
    chk("bad_digits", digits, 24'h123E56);
`endif
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    m_err = 0;
    @(negedge clk);
    chk("clr_err", err, 0);
    repeat (7) scan(24'h543210, 0, 7, STAB - 2);
    blank(5);
    chk("glitch_stale", stale, 1);
    chk("glitch_nstb", nstb, 4);
    scan(24'h123456, 0, 7, 64);
    chk("stale_cleared", stale, 0);
    chk("after_glitch_nstb", nstb, 5);
    for (int d = 0; d < 3; d++) strobe(8'(1 << d), pat[9], 0, 64);
    blank(1);
    #1 rst = 0;
    {m_seen, m_slot, m_dp, m_pub, m_pubdp} = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1;
    scan(24'h000000, 0, 7, 64);
    chk("reset_digits", digits, 24'h000000);
    chk("reset_nstb", nstb, 6);
    scan(24'h123456, 0, 7, 64);
    scan(24'h256100, 0, 7, 64);
`ifdef SEG_RANGE_CHECK_EN
    chk("range_digits", digits, 24'h123456);
`else
    chk("range_digits", digits, 24'h256100);
`endif
    blank(10);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_nstb", nstb, 8);
    chk("final_err", err, m_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 7-segment display bus driven by the clock/alarm top level.
- Samples the scanned segment (`seg7`) and digit-select (`number`) lines and waits for each strobe to settle.
- Decodes each glyph back to BCD and assembles a six-digit frame (sec/min/hour).
- Used for on-board loopback self-check and bench monitoring of the display path.

Parameters:
- NUM_DIGITS, 6, digit positions captured per frame (number[NUM_DIGITS-1:0]; upper bits ignored).
- STABLE_CYC, 16, consecutive identical samples required before a glyph is captured.
- TIMEOUT_CYC, 2000000, cycles without a capture before `stale` asserts.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0.
- DIG_ACTIVE_LOW, 1, 1 = digit selected when bit is 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- seg7  in  8  segments; [0]=a … [6]=g, [7]=dp
- number  in  8  digit select, one-hot when valid
- clr_err  in  1  synchronous clear of `err`
- digits  out  4*NUM_DIGITS  published frame; digit i at [4i+3:4i] (0=sec ones, 1=sec tens, 2/3 min, 4/5 hour)
- dp  out  NUM_DIGITS  published decimal points
- frame_stb  out  1  one-cycle pulse when a frame is published
- frame_valid  out  1  high after the first published frame
- err  out  1  sticky: undecodable glyph captured
- stale  out  1  no capture for TIMEOUT_CYC cycles
- range_err  out  1  see Optional Feature

Behaviour:
- Input path: `seg7` and `number` pass through 2-flop synchronisers. Polarity is normalised by the parameters to active-high (`s_seg`, `s_dig`).
- Strobe validity: `s_dig[NUM_DIGITS-1:0]` is exactly one-hot. Zero-hot or multi-hot is blanking.
- State machine, 3 states:
  - IDLE: valid strobe → SETTLE, with stab_cnt=1 and the pair (s_seg, s_dig) latched as reference.
  - SETTLE: sample equals reference → stab_cnt++. Sample differs → reload the reference and set stab_cnt=1 if valid, else → IDLE. When stab_cnt reaches STABLE_CYC → capture this cycle, then → HOLD.
  - HOLD: stays while the sample equals the reference. Any change → IDLE. A glyph is never captured twice in one strobe.
- Capture:
  - Decode s_seg[6:0] using the standard patterns 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F → 0–9.
  - 0x00 → 0xF (blank).
  - Any other pattern → 0xE and `err` set.
  - Result is written to working slot idx = position of the one-hot bit, `s_seg[7]` to working dp[idx], and seen[idx] is set.
- Frame publish:
  - Triggered when seen becomes all-ones; the capture that completes the mask counts.
  - Next cycle: working slots copy to `digits`/`dp`, `frame_stb`=1 for one cycle, `frame_valid`=1, seen clears.
  - A slot captured twice before the frame completes keeps its latest value.
- `err` is sticky until `clr_err` or reset. If `clr_err` and a new error occur in the same cycle, set wins.
- Timeout: idle_cnt counts from 0 (cleared on reset) and resets on every capture.
  - At TIMEOUT_CYC-1, `stale`=1 and seen clears, discarding partial frames.
  - `stale` clears on the next capture.
  - idle_cnt saturates at TIMEOUT_CYC-1.
- Reset values: digits=0, dp=0, frame_stb=0, frame_valid=0, err=0, stale=0, range_err=0, state=IDLE, seen=0, counters=0, synchronisers at the inactive level.
- Reset asserted mid-operation aborts any partial frame with no publish.
- Latency: strobe edge at the pin → capture in 2 + STABLE_CYC cycles; publish 1 cycle after the last capture.

Optional Feature:
- Macro: `SEG_RANGE_CHECK_EN`.
- Defined: at publish, the working frame is checked for a legal HH:MM:SS.
  - Legality: digit1≤5, digit3≤5, hour≤23, all digits ≤9.
  - Illegal frame: `digits`/`dp` are NOT updated, `range_err` pulses for one cycle, `frame_stb` still pulses, seen still clears.
- Undefined: no check; `range_err` is tied 0.

Test Plan:
- Drive a clean scan of 12:34:56 (digit0=6 … digit5=1), 64 cycles per digit, active-low → frame_stb once per scan; digits=0x123456; frame_valid=1; err=0.
- Glitch: each strobe holds its glyph only STABLE_CYC-2 cycles before switching → no capture, no frame_stb; stale=1 after TIMEOUT_CYC (use a small override, e.g. 500).
- Glyph 0x49 on digit 2 inside an otherwise valid frame → digit2=0xE, err=1; pulse clr_err → err=0.
- Multi-hot number (0b000011) held for 40 cycles between strobes → ignored, no capture; the following frame still publishes correctly.
- Reset pulse after 3 of 6 digits captured, then a full scan of 00:00:00 → exactly one frame_stb; digits=0x000000.
- With `SEG_RANGE_CHECK_EN`, scan 25:61:00 → range_err pulses; digits retain the previous 0x123456. Without it → digits=0x256100.
